dig_display_ctrl: RTL and testbench

Bus responder for the 8-digit 7-segment display on the peripheral side of the Bridge. It accepts CPU store transactions forwarded on the Bridge's dig interface (`rst_to_dig`/`clk_to_dig`/`addr_to_dig`/`wen_to_dig`/`wdata_to_dig`) and holds the 32-bit value. It time-multiplexes that value as 8 hex digits onto `dig_en`/`DN_*`. A shadow register is reloaded only at frame boundaries, so a write never shows a mix of old and new digits within one frame.

---
 rtl/dig_display_ctrl.sv | 106 ++++++++++
 tb/tb_dig_display_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dig_display_ctrl.sv
// 8-digit 7-segment scan controller: latches CPU stores to DIG_ADDR, scans
// the value as hex digits. Optional leading-zero blanking via DIG_LZ_BLANK_EN.
module dig_display_ctrl #(
  parameter int unsigned SCAN_DIV = 25000,
  parameter logic [31:0] DIG_ADDR = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [7:0]  dig_en,
  output logic        DN_A,
  output logic        DN_B,
  output logic        DN_C,
  output logic        DN_D,
  output logic        DN_E,
  output logic        DN_F,
  output logic        DN_G,
  output logic        DN_DP
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [31:0]      data_q;
  logic [31:0]      shadow_q;
  logic [6:0]       seg_q;

  logic             tick;
  logic             frame_end;
  logic             wr_hit;
  logic             blank;
  logic [3:0]       nib;
  logic [7:0]       en_next;
  logic [6:0]       seg_next;

  // Active-low segment pattern, bit order {A,B,C,D,E,F,G}.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (div_cnt == CNT_MAX);
    frame_end = tick && (idx == 3'd7);
    wr_hit    = wen && (addr == DIG_ADDR);
    nib       = shadow_q[{idx, 2'b00} +: 4];
`ifdef DIG_LZ_BLANK_EN
    blank     = (idx != 3'd0) && ((shadow_q >> {idx, 2'b00}) == 32'd0);
`else
    blank     = 1'b0;
`endif
    en_next   = blank ? '1 : ~(8'b1 << idx);
    seg_next  = blank ? '1 : hex_seg(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      shadow_q <= '0;
      div_cnt  <= '0;
      idx      <= '0;
      dig_en   <= '1;
      seg_q    <= '1;
    end else begin
      if (wr_hit)
        data_q <= wdata;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      // A store landing on the boundary edge goes straight to the shadow.
      if (frame_end)
        shadow_q <= wr_hit ? wdata : data_q;
      dig_en <= en_next;
      seg_q  <= seg_next;
    end
  end

  assign {DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G} = seg_q;
  assign DN_DP = 1'b1;

endmodule

// File: tb/tb_dig_display_ctrl.sv
// Randomized self-checking bench for dig_display_ctrl against a cycle-count
// reference model of the scan/shadow rules.
module tb_dig_display_ctrl;

  localparam int unsigned SD = 4;
  localparam logic [31:0] DIG = 32'hFFFF_F000;
`ifdef DIG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0]  dig_en;
  logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;
  logic [6:0]  seg;

  assign seg = {DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G};

  dig_display_ctrl #(.SCAN_DIV(SD), .DIG_ADDR(DIG)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wen(wen), .wdata(wdata),
    .dig_en(dig_en), .DN_A(DN_A), .DN_B(DN_B), .DN_C(DN_C), .DN_D(DN_D),
    .DN_E(DN_E), .DN_F(DN_F), .DN_G(DN_G), .DN_DP(DN_DP)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: n = edges since reset release; slot and frame position follow
  // from n by plain division.
  int unsigned n;
  logic [31:0] m_data, m_shadow;
  logic [7:0]  exp_en;
  logic [6:0]  exp_seg;
  int          tests = 0;
  int          fails = 0;

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int unsigned slot;
    logic [31:0] upper;
    logic        bl;
    rst_n = r; wen = w; addr = a; wdata = d;
    @(posedge clk);
    if (!r) begin
      n = 0; m_data = '0; m_shadow = '0;
      exp_en = 8'hFF; exp_seg = 7'h7F;
    end else begin
      slot  = (n / SD) % 8;
      upper = m_shadow >> (4 * slot);
      bl    = LZ && (slot != 0) && (upper == 0);
      exp_en  = bl ? 8'hFF : (8'hFF ^ (8'd1 << slot));
      exp_seg = bl ? 7'h7F : seg_tab[upper[3:0]];
      if (w && a == DIG) m_data = d;
      if (n % (8 * SD) == 8 * SD - 1) m_shadow = m_data;
      n++;
    end
    #1;
    wen = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0);
      tests++;
      if (dig_en !== 8'hFF || seg !== 7'h7F || DN_DP !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold: dig_en=%h seg=%b dp=%b, want FF 1111111 1", dig_en, seg, DN_DP);
      end
    end
    step(1'b1, 1'b0, '0, '0);
    tests++;
    if (dig_en !== 8'hFE || seg !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_release: dig_en=%h seg=%b, want FE 0000001", dig_en, seg);
    end
  endtask

  task automatic test_bad_addr();
    for (int i = 0; i < 80; i++) begin
      step(1'b1, (i == 2), DIG + 32'd4, $urandom | 32'h1);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg || DN_DP !== 1'b1) begin
        fails++;
        $display("FAIL bad_addr[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 64 && (n / SD) % 8 != 3; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL midframe_align: dig_en=%h seg=%b, want %h %b", dig_en, seg, exp_en, exp_seg);
      end
    end
    step(1'b1, 1'b1, DIG, 32'hFFFF_FFFF);
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL midframe[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_write_display();
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, DIG, 32'h1234_5678);
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL write_display[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 64 && n % (8 * SD) != 8 * SD - 1; i++)
      step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, DIG, 32'h0000_000A);
    step(1'b1, 1'b0, '0, '0);
    tests++;
    if (dig_en !== 8'hFE || seg !== 7'b0001000) begin
      fails++;
      $display("FAIL boundary_write: dig_en=%h seg=%b, want FE 0001000", dig_en, seg);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL boundary[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64 && n % (8 * SD) != 2; i++)
      step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, DIG, $urandom);
    step(1'b1, 1'b1, DIG, $urandom);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, DIG, $urandom);
    for (int i = 0; i < 72; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL back_to_back[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_blank();
    step(1'b1, 1'b1, DIG, 32'h0000_0305);
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL blank[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? (DIG ^ (32'd1 << $urandom_range(0, 31))) : DIG;
      step(1'b1, ($urandom_range(0, 7) == 0), a,
           ($urandom_range(0, 1) == 0) ? ($urandom >> ($urandom_range(0, 7) * 4)) : $urandom);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg || DN_DP !== 1'b1) begin
        fails++;
        $display("FAIL random[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, DIG, 32'h8765_4321);
    for (int i = 0; i < 64 && (n / SD) % 8 != 5; i++)
      step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    tests++;
    if (dig_en !== 8'hFF || seg !== 7'h7F || DN_DP !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: dig_en=%h seg=%b, want FF 1111111", dig_en, seg);
    end
    step(1'b1, 1'b0, '0, '0);
    tests++;
    if (dig_en !== 8'hFE || seg !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_mid_release: dig_en=%h seg=%b, want FE 0000001", dig_en, seg);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, '0, '0);
      tests++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        fails++;
        $display("FAIL reset_mid_scan[%0d]: dig_en=%h seg=%b, want %h %b", i, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  initial begin
    n = 0; m_data = '0; m_shadow = '0;
    exp_en = 8'hFF; exp_seg = 7'h7F;
    #1;
    test_reset();
    test_bad_addr();
    test_midframe();
    test_write_display();
    test_boundary();
    test_back_to_back();
    test_blank();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
